// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS32 core: stall vector, exception flush/redirect,
// post-flush recovery window, stall/flush statistics and a stall watchdog.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal operation; exceptions flush, stall requests honoured
// ST_RECOVER | post-flush window; exceptions and stall requests ignored
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          RECOVER_CYCLES = 1,
  parameter int          WDOG_LIMIT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o,
  output logic        wdog_timeout_o
);

  typedef enum logic {ST_RUN, ST_RECOVER} state_t;

  localparam logic [3:0]  REC_LOAD  = 4'(RECOVER_CYCLES - 1);
  localparam logic [15:0] WDOG_MAX  = 16'(WDOG_LIMIT);
  localparam logic [15:0] WDOG_TRIG = 16'(WDOG_LIMIT - 1);
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  state_t      state_q, state_d;
  logic [3:0]  rec_cnt_q, rec_cnt_d;
  logic [15:0] wdog_cnt_q;
  logic        stall_any;

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    stall_o   = 6'b000000;
    flush_o   = 1'b0;
    new_pc_o  = 32'h0;
    case (state_q)
      ST_RUN: begin
        if (excepttype_i != 32'h0) begin
          flush_o   = 1'b1;
          new_pc_o  = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
          state_d   = ST_RECOVER;
          rec_cnt_d = REC_LOAD;
        end else if (stallreq_mem) begin
          stall_o = 6'b011111;
        end else if (stallreq_ex) begin
          stall_o = 6'b001111;
        end else if (stallreq_id) begin
          stall_o = 6'b000111;
        end else if (stallreq_if) begin
          stall_o = 6'b000011;
        end
      end
      ST_RECOVER: begin
        if (rec_cnt_q == 4'd0) state_d = ST_RUN;
        else rec_cnt_d = rec_cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (!rst) begin
      stall_o  = 6'b000000;
      flush_o  = 1'b0;
      new_pc_o = 32'h0;
    end
  end

  assign stall_any = |stall_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      rec_cnt_q      <= 4'd0;
      stall_cycles_o <= 32'h0;
      flush_count_o  <= 16'h0;
      wdog_cnt_q     <= 16'h0;
      wdog_timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      if (stall_any && (stall_cycles_o != 32'hFFFF_FFFF))
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_o && (flush_count_o != 16'hFFFF))
        flush_count_o <= flush_count_o + 16'd1;
      // Watchdog count saturates at the limit; the flag itself is sticky.
      if (stall_any) begin
        if (wdog_cnt_q != WDOG_MAX) wdog_cnt_q <= wdog_cnt_q + 16'd1;
        if (wdog_cnt_q == WDOG_TRIG) wdog_timeout_o <= 1'b1;
      end else begin
        wdog_cnt_q <= 16'h0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and RECOVER_CYCLES=3/WDOG_LIMIT=8) share
// stimulus; a behavioural model is compared every cycle, plus directed literal checks.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic [31:0] exc, epc;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1;
  logic [31:0] pc0, pc1;
  logic [31:0] sc0, sc1;
  logic [15:0] fc0, fc1;
  logic        wd0, wd1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut0 (
    .clk(clk), .rst(rst), .stallreq_if(sr_if), .stallreq_id(sr_id),
    .stallreq_ex(sr_ex), .stallreq_mem(sr_mem), .excepttype_i(exc), .cp0_epc_i(epc),
    .stall_o(stall0), .flush_o(flush0), .new_pc_o(pc0), .stall_cycles_o(sc0),
    .flush_count_o(fc0), .wdog_timeout_o(wd0)
  );

  pipe_ctrl #(.RECOVER_CYCLES(3), .WDOG_LIMIT(8)) u_dut1 (
    .clk(clk), .rst(rst), .stallreq_if(sr_if), .stallreq_id(sr_id),
    .stallreq_ex(sr_ex), .stallreq_mem(sr_mem), .excepttype_i(exc), .cp0_epc_i(epc),
    .stall_o(stall1), .flush_o(flush1), .new_pc_o(pc1), .stall_cycles_o(sc1),
    .flush_count_o(fc1), .wdog_timeout_o(wd1)
  );

  // Behavioural model: rec_left counts recovery cycles still to be spent (0 = running).
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  int      m_rc [2] = '{1, 3};
  int      m_wl [2] = '{1024, 8};
  int      rec_left [2];
  longint  m_sc [2];
  int      m_fc [2];
  int      m_wcnt [2];
  bit      m_wd [2];

  function automatic exp_t model_out(int k);
    exp_t e;
    e.stall = 6'b0; e.flush = 1'b0; e.pc = 32'h0;
    if (rst && rec_left[k] == 0) begin
      if (exc != 0) begin
        e.flush = 1'b1;
        e.pc = (exc == 32'he) ? epc : 32'h20;
      end else if (sr_mem) e.stall = 6'b011111;
      else if (sr_ex)      e.stall = 6'b001111;
      else if (sr_id)      e.stall = 6'b000111;
      else if (sr_if)      e.stall = 6'b000011;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = model_out(k);
      if (!rst) begin
        rec_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_wcnt[k] = 0; m_wd[k] = 0;
      end else begin
        if (rec_left[k] > 0) rec_left[k] = rec_left[k] - 1;
        else if (e.flush) rec_left[k] = m_rc[k];
        if (e.stall != 0 && m_sc[k] < 64'hFFFF_FFFF) m_sc[k] = m_sc[k] + 1;
        if (e.flush && m_fc[k] < 16'hFFFF) m_fc[k] = m_fc[k] + 1;
        if (e.stall != 0) begin
          m_wcnt[k] = m_wcnt[k] + 1;
          if (m_wcnt[k] >= m_wl[k]) m_wd[k] = 1'b1;
        end else m_wcnt[k] = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      exp_t e0, e1;
      e0 = model_out(0);
      e1 = model_out(1);
      chk("d0.stall", 32'(stall0), 32'(e0.stall));
      chk("d0.flush", 32'(flush0), 32'(e0.flush));
      chk("d0.new_pc", pc0, e0.pc);
      chk("d0.stall_cycles", sc0, m_sc[0][31:0]);
      chk("d0.flush_count", 32'(fc0), 32'(m_fc[0]));
      chk("d0.wdog", 32'(wd0), 32'(m_wd[0]));
      chk("d1.stall", 32'(stall1), 32'(e1.stall));
      chk("d1.flush", 32'(flush1), 32'(e1.flush));
      chk("d1.new_pc", pc1, e1.pc);
      chk("d1.stall_cycles", sc1, m_sc[1][31:0]);
      chk("d1.flush_count", 32'(fc1), 32'(m_fc[1]));
      chk("d1.wdog", 32'(wd1), 32'(m_wd[1]));
    end
  end

  task automatic cyc(input logic r, input logic [3:0] req, input logic [31:0] ex,
                     input logic [31:0] ep = 32'h0);
    @(negedge clk);
    rst = r;
    {sr_mem, sr_ex, sr_id, sr_if} = req;
    exc = ex;
    epc = ep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 4'b0000, 32'h0);
  endtask

  initial begin
    rst = 1'b0; {sr_mem, sr_ex, sr_id, sr_if} = 4'b0; exc = 0; epc = 0;
    for (int k = 0; k < 2; k++) begin
      rec_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_wcnt[k] = 0; m_wd[k] = 0;
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, 32'h0);
    chk_en = 1'b1;

    idle(1); #3;
    chk("lit.reset_stall", 32'(stall0), 32'h0);
    chk("lit.reset_flush_count", 32'(fc0), 32'h0);
    idle(10); #3;
    chk("lit.idle_stall_cycles", sc0, 32'd0);

    cyc(1'b1, 4'b0001, 32'h0); #3; chk("lit.stall_if", 32'(stall0), 32'b000011);
    cyc(1'b1, 4'b0011, 32'h0); #3; chk("lit.stall_id", 32'(stall0), 32'b000111);
    cyc(1'b1, 4'b0111, 32'h0); #3; chk("lit.stall_ex", 32'(stall0), 32'b001111);
    cyc(1'b1, 4'b1111, 32'h0); #3; chk("lit.stall_mem", 32'(stall0), 32'b011111);
    idle(1); #3; chk("lit.stall_cycles4", sc0, 32'd4);

    cyc(1'b1, 4'b1000, 32'h8); #3;
    chk("lit.exc_flush", 32'(flush0), 32'h1);
    chk("lit.exc_stall", 32'(stall0), 32'h0);
    chk("lit.exc_pc", pc0, 32'h20);
    cyc(1'b1, 4'b1000, 32'h0); #3;
    chk("lit.recover_flush", 32'(flush0), 32'h0);
    chk("lit.recover_stall", 32'(stall0), 32'h0);
    cyc(1'b1, 4'b1000, 32'h0); #3;
    chk("lit.post_recover_stall", 32'(stall0), 32'b011111);
    chk("lit.flush_count1", 32'(fc0), 32'd1);
    idle(4);

    cyc(1'b1, 4'b0000, 32'he, 32'hBFC0_0100); #3;
    chk("lit.eret_flush", 32'(flush0), 32'h1);
    chk("lit.eret_pc", pc0, 32'hBFC0_0100);
    idle(4);

    cyc(1'b0, 4'b0000, 32'h0);
    cyc(1'b1, 4'b0000, 32'h8); #3; chk("lit.r3_first", 32'(flush1), 32'h1);
    cyc(1'b1, 4'b0000, 32'h8); #3; chk("lit.r3_second", 32'(flush1), 32'h0);
    idle(3); #3; chk("lit.r3_fc1", 32'(fc1), 32'd1);

    cyc(1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'b0000, 32'h8); #3;
      chk("lit.r3_hold", 32'(flush1), (i == 0 || i == 4) ? 32'h1 : 32'h0);
    end
    cyc(1'b1, 4'b0000, 32'h0); #3; chk("lit.r3_fc2", 32'(fc1), 32'd2);
    idle(3);

    cyc(1'b0, 4'b0000, 32'h0);
    idle(1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'b0100, 32'h0);
    idle(1); #3; chk("lit.wdog7", 32'(wd1), 32'h0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'b0100, 32'h0);
    idle(1); #3; chk("lit.wdog8", 32'(wd1), 32'h1);
    idle(3); #3; chk("lit.wdog_sticky", 32'(wd1), 32'h1);
    cyc(1'b0, 4'b0000, 32'h0);
    idle(1); #3; chk("lit.wdog_reset", 32'(wd1), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ex;
      logic [3:0]  req;
      ex = 32'h0;
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: ex = 32'h8;
          1: ex = 32'he;
          default: ex = $urandom;
        endcase
      end
      req = ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom_range(15));
      cyc(($urandom_range(99) != 0), req, ex, $urandom);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
